// File: rtl/sample_feed_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sample_feed_tx_pkg
// Description : Shared definitions for the gps_data sample-feed bus.
//               Holds the gps_data bit positions (also used by the tracking
//               channel top) and the transmitter FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sample_feed_tx_pkg;

    // gps_data bit positions
    localparam int GPS_DATA_LSB      = 0;
    localparam int GPS_DATA_MSB      = 2;
    localparam int GPS_CLK_SAMPLE    = 3;
    localparam int GPS_FEED_COMPLETE = 6;
    localparam int GPS_RESET         = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_FEED = 2'd2,
        ST_DONE = 2'd3
    } feed_state_t;

endpackage
`default_nettype wire

// File: rtl/sample_feed_tx_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : sample_clk_gen
// Description : clk_sample generator. Counts half_period system clocks per
//               phase and toggles the sample clock level.
// Ports       : clk, reset      - system clock, async active-high reset
//               enable          - run the divider; low forces level 0
//               half_period     - latched half period (never 0)
//               hold_low        - stall: keep level low, restart phase count
//               clk_sample      - registered sample clock level
//               fall / rise     - strobes: level changes at this clk edge
// Revision    : 1.0 - initial release
// ============================================================================
module sample_clk_gen
    import sample_feed_tx_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] half_period,
    input  logic                 hold_low,
    output logic                 clk_sample,
    output logic                 fall,
    output logic                 rise
);

    logic [DIV_WIDTH-1:0] count;
    logic                 terminal;

    // Compares against the latched half period, so the counter never wraps.
    assign terminal = (count == (half_period - DIV_WIDTH'(1)));
    assign rise     = enable && !hold_low && !clk_sample && terminal;
    assign fall     = enable && clk_sample && terminal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            clk_sample <= 1'b0;
        end else if (!enable || hold_low) begin
            // Holding the count at zero makes the low phase restart from
            // the cycle a stalled sample is finally accepted.
            count      <= '0;
            clk_sample <= 1'b0;
        end else if (terminal) begin
            count      <= '0;
            clk_sample <= ~clk_sample;
        end else begin
            count      <= count + DIV_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sample_feed_tx.sv
`default_nettype none
// ============================================================================
// Module      : sample_feed_tx
// Description : Sample-feed transmitter. Pulls 3-bit samples from a
//               valid/ready source and drives them onto gps_data with a
//               generated clk_sample, a leading reset interval and a
//               trailing feed_complete flag.
// Ports       : clk, reset                 - clock, async active-high reset
//               start, abort               - single-cycle run control
//               half_period, num_samples   - run setup, latched on start
//               sample_valid/data/ready    - sample source handshake
//               gps_data                   - {reset, feed_complete, 00,
//                                             clk_sample, data[2:0]}
//               busy, underrun             - status
// Revision    : 1.0 - initial release
// ============================================================================
module sample_feed_tx
    import sample_feed_tx_pkg::*;
#(
    parameter int DIV_WIDTH     = 16,
    parameter int LEN_WIDTH     = 24,
    parameter int RESET_PERIODS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DIV_WIDTH-1:0] half_period,
    input  logic [LEN_WIDTH-1:0] num_samples,
    input  logic                 sample_valid,
    input  logic [2:0]           sample_data,
    output logic                 sample_ready,
    output logic [7:0]           gps_data,
    output logic                 busy,
    output logic                 underrun
);

    localparam int PER_WIDTH = $clog2(RESET_PERIODS + 1);

    feed_state_t            state, state_d;
    logic [DIV_WIDTH-1:0]   half_q, half_d;
    logic [LEN_WIDTH-1:0]   num_q, num_d;
    logic [LEN_WIDTH-1:0]   sample_cnt, sample_cnt_d;
    logic [PER_WIDTH-1:0]   period_cnt, period_cnt_d;
    logic                   stalled, stalled_d;
    logic [2:0]             data_q, data_d;
    logic                   rst_q, rst_d;
    logic                   done_q, done_d;
    logic                   ready_d;
    logic                   underrun_d;
    logic                   fetch;

    logic                   gen_enable;
    logic                   gen_clk;
    logic                   gen_fall;
    logic                   gen_rise;

    // Abort is folded into the enable so clk_sample is already low in the
    // cycle after the abort.
    assign gen_enable = ((state == ST_RST) || (state == ST_FEED)) && !abort;

    sample_clk_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_clk_gen (
        .clk         (clk),
        .reset       (reset),
        .enable      (gen_enable),
        .half_period (half_q),
        .hold_low    (stalled),
        .clk_sample  (gen_clk),
        .fall        (gen_fall),
        .rise        (gen_rise)
    );

    always_comb begin
        state_d      = state;
        half_d       = half_q;
        num_d        = num_q;
        sample_cnt_d = sample_cnt;
        period_cnt_d = period_cnt;
        stalled_d    = stalled;
        data_d       = data_q;
        rst_d        = rst_q;
        done_d       = done_q;
        ready_d      = 1'b0;
        underrun_d   = underrun;
        fetch        = 1'b0;

        if (abort) begin
            state_d   = ST_IDLE;
            stalled_d = 1'b0;
            data_d    = 3'd0;
            rst_d     = 1'b0;
            done_d    = 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d      = ST_RST;
                        half_d       = (half_period == '0) ? DIV_WIDTH'(1) : half_period;
                        num_d        = num_samples;
                        sample_cnt_d = '0;
                        period_cnt_d = '0;
                        stalled_d    = 1'b0;
                        data_d       = 3'd0;
                        rst_d        = 1'b1;
                        done_d       = 1'b0;
                        underrun_d   = 1'b0;
                    end
                end
                ST_RST: begin
                    // A period counts as complete at its rise; the interval
                    // ends on the fall that closes the last one.
                    if (gen_rise) begin
                        period_cnt_d = period_cnt + PER_WIDTH'(1);
                    end
                    if (gen_fall && (period_cnt == PER_WIDTH'(RESET_PERIODS))) begin
                        rst_d = 1'b0;
                        if (num_q == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_FEED;
                            fetch   = 1'b1;
                        end
                    end
                end
                ST_FEED: begin
                    if (stalled) begin
                        fetch = 1'b1;
                    end else if (gen_fall) begin
                        if (sample_cnt == num_q) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            data_d  = 3'd0;
                        end else begin
                            fetch = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Start of a low phase: take the next sample or stall until one
        // is offered.
        if (fetch) begin
            if (sample_valid) begin
                ready_d      = 1'b1;
                data_d       = sample_data;
                sample_cnt_d = sample_cnt + LEN_WIDTH'(1);
                stalled_d    = 1'b0;
            end else begin
                stalled_d    = 1'b1;
                underrun_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            half_q       <= '0;
            num_q        <= '0;
            sample_cnt   <= '0;
            period_cnt   <= '0;
            stalled      <= 1'b0;
            data_q       <= 3'd0;
            rst_q        <= 1'b0;
            done_q       <= 1'b0;
            sample_ready <= 1'b0;
            busy         <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state        <= state_d;
            half_q       <= half_d;
            num_q        <= num_d;
            sample_cnt   <= sample_cnt_d;
            period_cnt   <= period_cnt_d;
            stalled      <= stalled_d;
            data_q       <= data_d;
            rst_q        <= rst_d;
            done_q       <= done_d;
            sample_ready <= ready_d;
            busy         <= (state_d == ST_RST) || (state_d == ST_FEED);
            underrun     <= underrun_d;
        end
    end

    always_comb begin
        gps_data                                = 8'h00;
        gps_data[GPS_DATA_MSB:GPS_DATA_LSB]     = data_q;
        gps_data[GPS_CLK_SAMPLE]                = gen_clk;
        gps_data[GPS_FEED_COMPLETE]             = done_q;
        gps_data[GPS_RESET]                     = rst_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sample_feed_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_feed_tx
// Description : Self-checking bench for sample_feed_tx. Expected cycle-by-
//               cycle outputs come from an event-time model: accept times
//               are derived arithmetically from the phase lengths and the
//               source's withhold times.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_feed_tx;

    localparam int RP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] half_period;
    logic [23:0] num_samples;
    logic        sample_valid;
    logic [2:0]  sample_data;
    logic        sample_ready;
    logic [7:0]  gps_data;
    logic        busy;
    logic        underrun;

    int          tests = 0;
    int          fails = 0;
    logic [2:0]  samp [16];
    int          stl  [16];

    sample_feed_tx #(
        .DIV_WIDTH     (16),
        .LEN_WIDTH     (24),
        .RESET_PERIODS (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .half_period  (half_period),
        .num_samples  (num_samples),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .gps_data     (gps_data),
        .busy         (busy),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    // mode 0: full run to DONE; mode 1: abort+start at cycle cut;
    // mode 2: stop after checking cycle cut (run left in progress).
    task automatic run(input string name, input int hp, input int n, input int mode,
                       input int cut, input int extra_start);
        int hpe, f1, e, last, und_from, k, rel, idx, wcnt, rdy_cnt;
        int acc [16];
        logic [10:0] got, expv;
        logic e_rst, e_done, e_busy, e_clk, e_rdy, e_und;
        logic [2:0] e_dat;

        hpe      = (hp == 0) ? 1 : hp;
        f1       = 2 * hpe * RP;
        und_from = -1;
        for (int i = 0; i < n; i++) begin
            int f, v;
            f      = (i == 0) ? f1 : acc[i-1] + 2 * hpe;
            v      = (i == 0) ? stl[0] + 1 : acc[i-1] + 1 + stl[i];
            acc[i] = (v > f) ? v : f;
            if (acc[i] > f && und_from < 0) und_from = f + 1;
        end
        e    = (n == 0) ? f1 : acc[n-1] + 2 * hpe;
        last = (mode == 0) ? e + 2 : ((mode == 1) ? cut + 1 : cut);

        @(negedge clk);
        half_period  = 16'(hp);
        num_samples  = 24'(n);
        start        = 1'b1;
        abort        = 1'b0;
        sample_valid = 1'b0;
        sample_data  = 3'd0;
        idx          = 0;
        wcnt         = (n > 0) ? stl[0] : 0;
        rdy_cnt      = 0;
        @(posedge clk); #1;
        start        = 1'b0;
        half_period  = 16'($urandom);
        num_samples  = 24'($urandom);

        for (int c = 1; c <= last; c++) begin
            e_rst  = (c <= f1);
            e_done = (c > e);
            e_busy = (c <= e);
            e_clk  = 1'b0;
            e_rdy  = 1'b0;
            e_dat  = 3'd0;
            e_und  = (und_from >= 0) && (c >= und_from);
            if (c <= f1) begin
                e_clk = (((c - 1) / hpe) % 2) == 1;
            end else if (c <= e) begin
                k = -1;
                for (int i = 0; i < n; i++) if (acc[i] + 1 <= c) k = i;
                if (k >= 0) begin
                    e_dat = samp[k];
                    rel   = c - acc[k] - 1;
                    e_clk = (rel >= hpe) && (rel < 2 * hpe);
                    e_rdy = (rel == 0);
                end
            end
            if (mode == 1 && c > cut) begin
                e_rst = 0; e_done = 0; e_busy = 0; e_clk = 0; e_rdy = 0; e_dat = 3'd0;
            end
            expv = {e_rst, e_done, 2'b00, e_clk, e_dat, e_rdy, e_busy, e_und};
            got  = {gps_data, sample_ready, busy, underrun};
            tests++;
            if (got !== expv) begin
                fails++;
                $display("FAIL %s cycle %0d: got gps_data=%h ready=%b busy=%b underrun=%b, expected gps_data=%h ready=%b busy=%b underrun=%b",
                         name, c, got[10:3], got[2], got[1], got[0], expv[10:3], expv[2], expv[1], expv[0]);
            end

            // Source: after each accept, withhold valid for stl[idx] cycles.
            if (sample_ready === 1'b1) begin
                rdy_cnt++;
                if (idx < n) idx++;
                wcnt = (idx < n) ? stl[idx] : 0;
            end
            if (wcnt > 0) begin
                sample_valid = 1'b0;
                wcnt--;
            end else begin
                sample_valid = (idx < n);
            end
            sample_data = (idx < n) ? samp[idx] : 3'd0;
            start       = (c == extra_start);
            abort       = (mode == 1) && (c == cut);
            if (abort) start = 1'b1;
            if (c < last) begin
                @(posedge clk); #1;
            end
        end
        start        = 1'b0;
        abort        = 1'b0;
        sample_valid = 1'b0;
        if (mode == 0) begin
            tests++;
            if (rdy_cnt != n) begin
                fails++;
                $display("FAIL %s ready_pulses: got %0d, expected %0d", name, rdy_cnt, n);
            end
        end
    endtask

    task automatic clear_stalls();
        for (int i = 0; i < 16; i++) stl[i] = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({gps_data, sample_ready, busy, underrun} !== 11'd0) begin
            fails++;
            $display("FAIL reset_state: got gps_data=%h ready=%b busy=%b underrun=%b, expected all 0",
                     gps_data, sample_ready, busy, underrun);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({gps_data, busy} !== 9'd0) begin
            fails++;
            $display("FAIL idle_after_reset: got gps_data=%h busy=%b, expected 00/0", gps_data, busy);
        end
    endtask

    task automatic test_basic();
        clear_stalls();
        samp[0] = 3'd5; samp[1] = 3'd2; samp[2] = 3'd7;
        run("basic", 2, 3, 0, 0, 0);
    endtask

    task automatic test_underrun();
        clear_stalls();
        samp[0] = 3'd3; samp[1] = 3'd6; samp[2] = 3'd1;
        stl[1]  = 8;   // valid returns 5 cycles after the second fetch point
        run("underrun", 2, 3, 0, 0, 0);
    endtask

    task automatic test_restart_from_done();
        clear_stalls();
        samp[0] = 3'd4; samp[1] = 3'd0; samp[2] = 3'd7;
        run("restart", 2, 3, 0, 0, 18);
    endtask

    task automatic test_abort();
        clear_stalls();
        samp[0] = 3'd1; samp[1] = 3'd2; samp[2] = 3'd3; samp[3] = 3'd4;
        run("abort", 2, 4, 1, 22, 0);
        samp[0] = 3'd6; samp[1] = 3'd5;
        run("after_abort", 2, 2, 0, 0, 0);
    endtask

    task automatic test_edges();
        clear_stalls();
        run("zero_samples", 3, 0, 0, 0, 0);
        samp[0] = 3'd7; samp[1] = 3'd1;
        run("half_zero", 0, 2, 0, 0, 0);
        run("half_one", 1, 2, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        clear_stalls();
        samp[0] = 3'd2; samp[1] = 3'd5; samp[2] = 3'd3; samp[3] = 3'd6;
        stl[1]  = 7;
        run("async_pre", 2, 4, 2, 26, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if ({gps_data, sample_ready, busy, underrun} !== 11'd0) begin
            fails++;
            $display("FAIL async_reset: got gps_data=%h ready=%b busy=%b underrun=%b, expected all 0",
                     gps_data, sample_ready, busy, underrun);
        end
        #2;
        reset = 1'b0;
        clear_stalls();
        run("after_reset", 1, 3, 0, 0, 0);
    endtask

    task automatic test_random();
        int hp, n, hpe;
        for (int r = 0; r < 8; r++) begin
            hp  = $urandom_range(0, 3);
            n   = $urandom_range(0, 6);
            hpe = (hp == 0) ? 1 : hp;
            for (int i = 0; i < 16; i++) begin
                samp[i] = 3'($urandom);
                stl[i]  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2 * hpe + 3) : 0;
            end
            run("random", hp, n, 0, 0, (n > 0 && r[0]) ? 2 * hpe * RP + 1 : 0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        half_period  = 16'd0;
        num_samples  = 24'd0;
        sample_valid = 1'b0;
        sample_data  = 3'd0;
        test_reset();
        test_basic();
        test_underrun();
        test_restart_from_done();
        test_abort();
        test_edges();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/sample_feed_tx.md
# sample_feed_tx

Hardware transmitter for the 8-bit `gps_data` sample-feed bus consumed by the tracking channel. It pulls 3-bit IF samples from a valid/ready source, generates `clk_sample` from the system clock, and frames each run with a leading `reset` interval and a trailing `feed_complete` flag. It replaces the software PIO feed so the channel can be driven at a deterministic sample rate.

## Interface
- `DIV_WIDTH`, 16, width of the half-period divider
- `LEN_WIDTH`, 24, width of the sample count
- `RESET_PERIODS`, 4, number of `clk_sample` periods held in `reset` before data
---
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle run request.
- `abort` in 1: single-cycle cancel.
- `half_period` in DIV_WIDTH: `clk` cycles per `clk_sample` half period. A value of 0 is treated as 1.
- `num_samples` in LEN_WIDTH: number of samples in the run.
- `sample_valid` in 1: source has a sample available.
- `sample_data` in 3: sample value.
- `sample_ready` out 1: one-cycle accept strobe.
- `gps_data` out 8: bit layout is [2:0] data, [3] `clk_sample`, [5:4] always 0, [6] `feed_complete`, [7] `reset`.
- `busy` out 1: high in RST and FEED.
- `underrun` out 1: sticky. Cleared by `reset` or by an accepted `start`.

## Operation
- All outputs are registered. Every output resets to 0.
- FSM states are IDLE, RST, FEED and DONE.
- **IDLE / DONE → RST** on `start` (`abort` low):
  - latch `half_period` (0→1) and `num_samples`;
  - clear `underrun`, clear `feed_complete`;
  - set `gps_data[7]`=1, `clk_sample`=0, data=0.
- **RST:**
  - `clk_sample` toggles every `half_period` cycles;
  - after RESET_PERIODS complete periods (low then high, ending on the falling edge), drop `gps_data[7]`;
  - go to FEED, or to DONE if `num_samples`==0.
- **FEED:**
  - Each sample period is a low phase followed by a high phase.
  - At the start of each low phase with `sample_valid`=1: pulse `sample_ready` and register `sample_data` onto [2:0] in the same cycle.
  - If `sample_valid`=0 at that point: stall with `clk_sample` held low and data held, set `underrun`, and retry each cycle. The low phase of `half_period` cycles counts from the accept.
  - After the high phase of sample `num_samples`, `clk_sample` falls and the FSM goes to DONE.
- **DONE:**
  - `feed_complete`=1, data=0, `clk_sample`=0;
  - held until the next `start` or `abort`.
- **`abort`** in any state → IDLE next cycle with all `gps_data` bits 0. `abort` wins over a simultaneous `start`.
- `start` during RST or FEED is ignored.
- `sample_ready` is asserted only in FEED. It is never asserted in the same cycle as `abort`.

## Timing
- `start` sampled at cycle 0 → `gps_data[7]`=1 at cycle 1. The first `clk_sample` rise is at cycle 1+`half_period`.
- Data changes only coincident with a `clk_sample` falling edge, or at the first low phase. The receiver therefore sees data stable for ≥`half_period` cycles around each rising edge.
- Unstalled sample rate is `clk`/(2·`half_period`).
- Run length without stalls is 1 + 2·`half_period`·(RESET_PERIODS+`num_samples`) cycles from `start` to `feed_complete`=1.
- The sample counter and the divider are LEN_WIDTH and DIV_WIDTH bits respectively. They do not wrap, because they compare against latched values.
- Async `reset` mid-run clears everything immediately.
- A `start` sampled at cycle 0 in DONE drops `feed_complete` at cycle 1.

## Structure
- The shared header holds:
  - `gps_data` bit-position constants (DATA range, CLK_SAMPLE, FEED_COMPLETE, RESET), also used by the channel top;
  - FSM state encoding.
- One sub-module, `sample_clk_gen`:
  - divider plus phase toggle;
  - inputs: enable, latched half period, hold-low (stall);
  - outputs: `clk_sample` level, fall strobe, rise strobe.
- The FSM and the sample/period counters sit in `sample_feed_tx`.

## Test plan
- **Basic run.** `half_period`=2, `num_samples`=3, samples 5,2,7 always valid, RESET_PERIODS=4 → `gps_data[7]` high for cycles 1–16. Data 5/2/7 appears at cycles 17/21/25. `feed_complete`=1 at cycle 29. Exactly three `sample_ready` pulses.
- **Underrun.** `sample_valid` withheld for 5 cycles at the second sample → `clk_sample` stays low 5 extra cycles, `underrun`=1, data correct, run ends 5 cycles late.
- **Abort.** `abort` mid-FEED with `start` in the same cycle → next cycle `gps_data`=0x00, `busy`=0, FSM in IDLE. A later `start` runs normally.
- **Edge values.** `num_samples`=0 → no `sample_ready`, `feed_complete` after the RST interval. `half_period`=0 behaves identically to 1.
- **Async reset.** Assert `reset` between clock edges during FEED → all outputs 0 before the next `clk` edge. A subsequent `start` works.
- **Restart from DONE.** `start` in DONE → `feed_complete` drops at cycle 1, `underrun` cleared, new run begins. A `start` issued during FEED has no effect.
